// File: rtl/dot8_pkg.sv
// Shared types and constants for the eight-lane Q16.16 dot-product engine.
package dot8_pkg;

  localparam int ELEM_W    = 32;
  localparam int LANES     = 8;
  localparam int FRAC_BITS = 16;

  typedef logic signed [ELEM_W-1:0] q16_t;

  typedef enum logic [1:0] {
    IDLE_RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dot8_accum_ctrl_if.sv
// Chunk/result bus between the vector wrapper (master) and the dot-product engine (slave).
interface dot8_accum_ctrl_if;
  import dot8_pkg::*;

  logic [LANES*ELEM_W-1:0] first_row_input;
  logic [LANES*ELEM_W-1:0] second_row_input;
  logic                    outsider_read_now;
  logic [ELEM_W-1:0]       result;
  logic                    finish;

  modport master (
    output first_row_input,
    output second_row_input,
    output outsider_read_now,
    input  result,
    input  finish
  );

  modport slave (
    input  first_row_input,
    input  second_row_input,
    input  outsider_read_now,
    output result,
    output finish
  );

endinterface

// File: rtl/dot8_accum_ctrl_q16_mul.sv
// Signed Q16.16 multiply; the arithmetic shift truncates toward -inf.
module q16_mul
  import dot8_pkg::*;
(
  input  q16_t a,
  input  q16_t b,
  output q16_t p
);

  localparam int FULL_W = ELEM_W + FRAC_BITS;

  // Only bits [47:16] of the full product survive, so a 48-bit product suffices.
  logic signed [FULL_W-1:0] full;

  assign full = FULL_W'(a) * FULL_W'(b);
  assign p    = q16_t'(full >>> FRAC_BITS);

endmodule

// File: rtl/dot8_accum_ctrl.sv
// Eight-lane dot-product engine: product stage, adder-tree stage, accumulator, chunk control.
module dot8_accum_ctrl
  import dot8_pkg::*;
#(
  parameter int NOE = 16
) (
  input  logic               clk,
  input  logic               reset,
  dot8_accum_ctrl_if.slave   bus
);

  localparam int CHUNKS = (NOE + LANES - 1) / LANES;
  localparam int CNT_W  = (CHUNKS < 2) ? 1 : $clog2(CHUNKS + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             v0_reg;
  logic             v1_reg;
  logic             finish_reg;
  q16_t             acc_reg;
  q16_t             sum_reg;
  q16_t             prod_reg  [LANES];
  q16_t             prod_next [LANES];
  q16_t             a_lane    [LANES];
  q16_t             b_lane    [LANES];
  q16_t             p_lane    [LANES];
  logic             lane_live [LANES];
  q16_t             l1_sum    [LANES/2];
  q16_t             l2_sum    [LANES/4];
  q16_t             sum_next;
  logic             accept;

  assign accept = (state_reg == IDLE_RUN) && bus.outsider_read_now;

  // Lanes past NOE in the final chunk contribute zero regardless of their data.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign a_lane[gi]    = bus.first_row_input[gi*ELEM_W +: ELEM_W];
      assign b_lane[gi]    = bus.second_row_input[gi*ELEM_W +: ELEM_W];
      assign lane_live[gi] = (int'(beat_cnt_reg) * LANES + gi) < NOE;
      assign prod_next[gi] = lane_live[gi] ? p_lane[gi] : '0;

      q16_mul u_mul (
        .a (a_lane[gi]),
        .b (b_lane[gi]),
        .p (p_lane[gi])
      );
    end

    for (genvar gi = 0; gi < LANES/2; gi++) begin : g_l1
      assign l1_sum[gi] = prod_reg[2*gi] + prod_reg[2*gi+1];
    end

    for (genvar gi = 0; gi < LANES/4; gi++) begin : g_l2
      assign l2_sum[gi] = l1_sum[2*gi] + l1_sum[2*gi+1];
    end
  endgenerate

  assign sum_next = l2_sum[0] + l2_sum[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE_RUN;
      beat_cnt_reg <= '0;
      v0_reg       <= 1'b0;
      v1_reg       <= 1'b0;
      finish_reg   <= 1'b0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_reg[i] <= '0;
      end
    end else begin
      v0_reg <= accept;
      if (accept) begin
        prod_reg <= prod_next;
      end

      v1_reg <= v0_reg;
      if (v0_reg) begin
        sum_reg <= sum_next;
      end

      if (v1_reg) begin
        acc_reg <= acc_reg + sum_reg;
      end

      case (state_reg)
        IDLE_RUN: begin
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (beat_cnt_reg == CNT_W'(CHUNKS - 1)) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // No beats enter once draining, so the last one is in the
          // accumulate stage exactly when stage 1 is valid and stage 0 is not.
          if (v1_reg && !v0_reg) begin
            state_reg  <= DONE;
            finish_reg <= 1'b1;
          end
        end
        DONE: begin
          finish_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE_RUN;
        end
      endcase
    end
  end

  assign bus.result = acc_reg;
  assign bus.finish = finish_reg;

endmodule

// File: tb/tb_dot8_accum_ctrl.sv
// Directed bench for dot8_accum_ctrl with NOE=16 and NOE=12 instances sharing stimulus.
module tb_dot8_accum_ctrl;
  import dot8_pkg::*;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] TWO  = 32'h0002_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] NEG1 = 32'hFFFF_0000;

  logic clk;
  logic reset;
  logic [LANES*ELEM_W-1:0] a_vec;
  logic [LANES*ELEM_W-1:0] b_vec;
  logic rd;

  int n_checks;
  int n_errors;

  dot8_accum_ctrl_if bus16 ();
  dot8_accum_ctrl_if bus12 ();

  assign bus16.first_row_input   = a_vec;
  assign bus16.second_row_input  = b_vec;
  assign bus16.outsider_read_now = rd;
  assign bus12.first_row_input   = a_vec;
  assign bus12.second_row_input  = b_vec;
  assign bus12.outsider_read_now = rd;

  dot8_accum_ctrl #(.NOE(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  dot8_accum_ctrl #(.NOE(12)) u_dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*ELEM_W-1:0] splat(input logic [31:0] x);
    return {LANES{x}};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd    = 1'b0;
    a_vec = '0;
    b_vec = '0;
    step(2);
    reset = 1'b0;
  endtask

  // One accepted beat, sampled at the next rising edge.
  task automatic beat(input logic [LANES*ELEM_W-1:0] a, input logic [LANES*ELEM_W-1:0] b);
    a_vec = a;
    b_vec = b;
    rd    = 1'b1;
    @(posedge clk);
    $display("beat t=%0t a0=%h a7=%h b0=%h b7=%h", $time, a[31:0], a[255:224], b[31:0], b[255:224]);
    #1;
    rd = 1'b0;
  endtask

  logic [LANES*ELEM_W-1:0] va;
  logic [LANES*ELEM_W-1:0] vb;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Basic back-to-back beats: 8*2.0 + 8*(-0.5) = 12.0
    do_reset();
    check_val("rst_result", bus16.result, 32'h0);
    check_val("rst_finish", {31'b0, bus16.finish}, 32'h0);
    beat(splat(ONE), splat(TWO));
    beat(splat(HALF), splat(NEG1));
    step(1);
    check_val("basic_fin_early", {31'b0, bus16.finish}, 32'h0);
    step(1);
    check_val("basic_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("basic_result", bus16.result, 32'h000C_0000);
    step(3);
    check_val("basic_fin_hold", {31'b0, bus16.finish}, 32'h1);
    check_val("basic_res_hold", bus16.result, 32'h000C_0000);

    // Gapped beats: finish tracks the last sampling edge
    do_reset();
    beat(splat(ONE), splat(TWO));
    step(3);
    beat(splat(HALF), splat(NEG1));
    step(1);
    check_val("gap_fin_early", {31'b0, bus16.finish}, 32'h0);
    step(1);
    check_val("gap_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("gap_result", bus16.result, 32'h000C_0000);

    // Partial chunk: NOE=12 masks lanes 4-7 of beat 2; NOE=16 sums them and wraps
    do_reset();
    beat(splat(ONE), splat(ONE));
    va = {{4{32'h7FFF_0000}}, {4{ONE}}};
    beat(va, splat(ONE));
    step(2);
    check_val("part12_fin", {31'b0, bus12.finish}, 32'h1);
    check_val("part12_result", bus12.result, 32'h000C_0000);
    check_val("part16_result", bus16.result, 32'h0008_0000);

    // Post-finish beats are ignored
    do_reset();
    beat(splat(ONE), splat(TWO));
    beat(splat(HALF), splat(NEG1));
    beat(splat(ONE), splat(ONE));
    beat(splat(ONE), splat(ONE));
    beat(splat(ONE), splat(ONE));
    check_val("post_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("post_result", bus16.result, 32'h000C_0000);
    step(3);
    check_val("post_fin_hold", {31'b0, bus16.finish}, 32'h1);
    check_val("post_res_hold", bus16.result, 32'h000C_0000);

    // Truncation toward -inf: -1 LSB * 1 LSB -> -1 LSB
    do_reset();
    va = '0;
    va[31:0] = 32'hFFFF_FFFF;
    vb = splat(32'h0000_0001);
    beat(va, vb);
    beat('0, '0);
    step(2);
    check_val("trunc_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("trunc_result", bus16.result, 32'hFFFF_FFFF);

    // Wrap: 8 * 16384.0 = 2^17 wraps to zero, then lane 0 adds 1.0
    do_reset();
    beat(splat(32'h4000_0000), splat(ONE));
    step(1);
    check_val("wrap_partial", bus16.result, 32'h0);
    va = '0;
    va[31:0] = ONE;
    beat(va, splat(ONE));
    step(2);
    check_val("wrap_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("wrap_result", bus16.result, 32'h0001_0000);

    // Reset mid-run discards the in-flight beat
    do_reset();
    beat(splat(ONE), splat(TWO));
    reset = 1'b1;
    step(1);
    check_val("midrst_result", bus16.result, 32'h0);
    check_val("midrst_finish", {31'b0, bus16.finish}, 32'h0);
    reset = 1'b0;
    step(2);
    check_val("midrst_flush", bus16.result, 32'h0);
    check_val("midrst_fin_low", {31'b0, bus16.finish}, 32'h0);
    beat(splat(ONE), splat(ONE));
    beat(splat(ONE), splat(ONE));
    step(2);
    check_val("midrst_fin", {31'b0, bus16.finish}, 32'h1);
    check_val("midrst_result2", bus16.result, 32'h0010_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
